seq_bin_to_xs3: RTL and testbench
=================================

# seq_bin_to_xs3

Iterative, parametrised binary-to-decimal code converter. Accepts a WIDTH-bit unsigned binary word over a valid/ready handshake and converts it with shift-and-add-3 (double dabble), one bit per clock. Returns DIGITS decimal digits in either 8421 BCD or excess-3 code, selected per transaction. It sits in the code-converter library as the multi-digit, clocked successor to the single-digit combinational binary-to-excess-3 converter.

## Interface
Parameters:
- WIDTH, 8, binary input width; legal range 4..32.
- DIGITS, 3, number of output decimal digits; must satisfy 10^DIGITS > 2^WIDTH − 1. Elaboration fails otherwise.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_bin and in_mode are valid.
- in_ready  output  1  converter can accept a word.
- in_bin  input  WIDTH  unsigned binary operand.
- in_mode  input  1  0 = 8421 BCD, 1 = excess-3.
- out_valid  output  1  out_code holds a finished result.
- out_ready  input  1  consumer accepts the result.
- out_code  output  4*DIGITS  result; digit 0 (units) in bits [3:0].
- busy  output  1  high in CONV state.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture in_bin into a shift register, latch in_mode, clear the digit accumulator, load the bit counter with WIDTH−1, then enter CONV.
- CONV, one iteration per cycle:
  - Each 4-bit digit ≥ 5 gets +3.
  - Then {digits, shift register} shifts left by one.
  - The counter decrements.
  - When the counter is 0, the iteration completes and the FSM enters DONE.
  - On that final iteration's register load, if the latched mode = 1, +3 is added to every digit (excess-3). Digits never carry into each other, since a digit ≤ 9 gives ≤ 12.
- DONE:
  - out_valid = 1; out_code stays stable.
  - On out_ready, return to IDLE.
  - in_ready = 0 (no overlap of transactions).
- in_valid and in_bin are ignored outside IDLE. in_mode is sampled only at acceptance.
- Upper digits beyond the value's magnitude read 0000 (BCD) or 0011 (excess-3).

## Timing
- Reset values: in_ready = 1, out_valid = 0, busy = 0, out_code = 0, FSM = IDLE.
- Acceptance on edge T gives CONV for WIDTH cycles. out_valid rises after edge T+WIDTH, so latency is WIDTH cycles from handshake to out_valid.
- Minimum throughput is one word per WIDTH+2 cycles: accept, WIDTH iterations, one DONE cycle with out_ready high, then back to IDLE.
- out_ready held low: DONE persists indefinitely with out_code stable.
- out_ready high before out_valid has no effect.
- Reset asserted mid-CONV or in DONE: all state clears asynchronously. The partial result is discarded and never presented.
- in_ready is a registered decode of the state; there is no combinational path from in_valid to in_ready.

## Structure
- Shared package conv_pkg holds:
  - state_t enum {IDLE, CONV, DONE}
  - MODE_BCD = 1'b0, MODE_XS3 = 1'b1
  - XS3_BIAS = 4'd3
  - DABBLE_THRESH = 4'd5
- Sub-module bcd_digit_adj is the combinational per-digit unit, instantiated DIGITS times via generate.
  - Inputs: a 4-bit digit, and a final flag gated by mode.
  - Output: the adjusted digit. This is +3 if the digit ≥ 5 before the shift, and +3 bias on the final excess-3 load.
- The top level contains the FSM, the counter, the shift register and the handshake logic.

## Test plan
All cases use WIDTH=8, DIGITS=3.
- in_bin=0, mode=1 -> out_code=12'h333; out_valid exactly 8 cycles after acceptance.
- in_bin=255, mode=0 -> 12'h255. Same operand with mode=1 -> 12'h588.
- Sweep in_bin=0..12, mode=1 -> units digit equals the single-digit excess-3 code for 0..9 (0011..1100). 10, 11 and 12 give 12'h343, 12'h344 and 12'h345.
- Backpressure: in_bin=137, mode=0, out_ready low for 5 cycles -> out_code=12'h137 held stable, in_ready=0 throughout, and a pulse on in_valid during DONE is ignored.
- Back-to-back: out_ready tied high with 42 then 99, both mode=1 -> 12'h375 then 12'h3CC; the second is accepted one cycle after the first DONE.
- Reset mid-CONV: pull rst_n low at iteration 4 -> outputs return to reset values immediately. A subsequent in_bin=7, mode=0 gives 12'h007.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the code-converter library.
// Also provides the elaboration-time digit-capacity check.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic       MODE_BCD      = 1'b0;
   localparam logic       MODE_XS3      = 1'b1;
   localparam logic [3:0] XS3_BIAS      = 4'd3;
   localparam logic [3:0] DABBLE_THRESH = 4'd5;
   localparam logic [3:0] DABBLE_ADD    = 4'd3;

   // True when d decimal digits can represent every w-bit unsigned value.
   function automatic bit digits_fit(input int w, input int d);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < d; i++) begin
         p = p * 64'd10;
      end
      return (d >= 1) && (p > ((64'd1 << w) - 64'd1));
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One decimal digit slice of the double-dabble datapath: add-3 correction,
// left shift with the bit from the lower digit, and optional excess-3 bias.
module bcd_digit_adj
   import conv_pkg::*;
(
   input  logic [3:0] dig_i,
   input  logic       shift_in_i,
   input  logic       bias_i,
   output logic [3:0] dig_o,
   output logic       shift_out_o
);

   logic [3:0] adj_s;
   logic [3:0] shifted_s;

   // Correct, shift, then bias; a digit <= 9 biased by 3 never exceeds 12.
   always_comb begin
      adj_s       = dig_i;
      shifted_s   = 4'd0;
      dig_o       = 4'd0;
      shift_out_o = 1'b0;
      if (dig_i >= DABBLE_THRESH) begin
         adj_s = dig_i + DABBLE_ADD;
      end else begin
         adj_s = dig_i;
      end
      shifted_s   = {adj_s[2:0], shift_in_i};
      shift_out_o = adj_s[3];
      if (bias_i) begin
         dig_o = shifted_s + XS3_BIAS;
      end else begin
         dig_o = shifted_s;
      end
   end

endmodule

// File: rtl/seq_bin_to_xs3.sv
// Iterative binary to BCD / excess-3 converter, one input bit per clock,
// with valid/ready handshakes on both sides and fully registered outputs.
module seq_bin_to_xs3
   import conv_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_bin,
   input  logic                  in_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_code,
   output logic                  busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   if (!(WIDTH >= 4 && WIDTH <= 32 && digits_fit(WIDTH, DIGITS))) begin : g_bad_params
      $error("seq_bin_to_xs3: illegal WIDTH/DIGITS combination");
   end

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      sr_q, sr_d;
   logic [4*DIGITS-1:0]   dig_q, dig_d, dig_nxt_s;
   logic [4*DIGITS-1:0]   out_code_q, out_code_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  mode_q, mode_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic                  busy_q, busy_d;
   logic [DIGITS-1:0]     chain_s;
   logic                  unused_carry_s;
   logic                  bias_s;

   assign chain_s[0] = sr_q[WIDTH-1];
   assign bias_s     = (cnt_q == CNT_W'(0)) && (mode_q == MODE_XS3);

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      if (g < DIGITS - 1) begin : g_mid
         bcd_digit_adj u_adj (
            .dig_i       (dig_q[4*g +: 4]),
            .shift_in_i  (chain_s[g]),
            .bias_i      (bias_s),
            .dig_o       (dig_nxt_s[4*g +: 4]),
            .shift_out_o (chain_s[g+1])
         );
      end else begin : g_top
         // Top carry is always zero because DIGITS covers the input range.
         bcd_digit_adj u_adj (
            .dig_i       (dig_q[4*g +: 4]),
            .shift_in_i  (chain_s[g]),
            .bias_i      (bias_s),
            .dig_o       (dig_nxt_s[4*g +: 4]),
            .shift_out_o (unused_carry_s)
         );
      end
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      dig_d      = dig_q;
      out_code_d = out_code_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sr_d    = in_bin;
               mode_d  = in_mode;
               dig_d   = '0;
               cnt_d   = CNT_W'(WIDTH - 1);
               state_d = CONV;
            end else begin
               state_d = IDLE;
            end
         end
         CONV: begin
            dig_d = dig_nxt_s;
            sr_d  = {sr_q[WIDTH-2:0], 1'b0};
            if (cnt_q == CNT_W'(0)) begin
               out_code_d = dig_nxt_s;
               state_d    = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d == CONV);
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         dig_q       <= '0;
         out_code_q  <= '0;
         cnt_q       <= '0;
         mode_q      <= MODE_BCD;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         dig_q       <= dig_d;
         out_code_q  <= out_code_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_code  = out_code_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_seq_bin_to_xs3.sv
// Directed-vector bench for seq_bin_to_xs3 (WIDTH=8, DIGITS=3).
module tb_seq_bin_to_xs3;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_bin;
   logic        in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_code;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   seq_bin_to_xs3 #(.WIDTH(8), .DIGITS(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bin    (in_bin),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Handshake one word; returns at the negedge right after the accepting edge.
   task automatic accept(input logic [7:0] b, input logic m);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b1;
      in_bin   = b;
      in_mode  = m;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Counts negedges until out_valid, bounded.
   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Consume a result in DONE with a one-cycle out_ready pulse.
   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_vec++;
      if ({in_ready, out_valid, busy, out_code} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
         n_err++;
         $display("FAIL reset: got rdy=%b vld=%b busy=%b code=%h, want 1 0 0 000",
                  in_ready, out_valid, busy, out_code);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_zero_latency();
      int n;
      accept(8'd0, 1'b1);
      n_vec++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL conv_flags: got busy=%b rdy=%b, want 1 0", busy, in_ready);
      end
      wait_valid(n);
      n_vec++;
      if (n !== 8) begin
         n_err++;
         $display("FAIL latency: got %0d cycles, want 8", n);
      end
      n_vec++;
      if (out_code !== 12'h333) begin
         n_err++;
         $display("FAIL zero_xs3: got %h, want 333", out_code);
      end
      drain();
   endtask

   task automatic test_max();
      int n;
      accept(8'd255, 1'b0);
      wait_valid(n);
      n_vec++;
      if (out_code !== 12'h255 || n !== 8) begin
         n_err++;
         $display("FAIL max_bcd: got %h after %0d, want 255 after 8", out_code, n);
      end
      drain();
      accept(8'd255, 1'b1);
      wait_valid(n);
      n_vec++;
      if (out_code !== 12'h588) begin
         n_err++;
         $display("FAIL max_xs3: got %h, want 588", out_code);
      end
      drain();
   endtask

   task automatic test_sweep();
      logic [11:0] exp_tab [13];
      logic [3:0]  unit_tab [10];
      int n;
      exp_tab = '{12'h333, 12'h334, 12'h335, 12'h336, 12'h337, 12'h338, 12'h339,
                  12'h33A, 12'h33B, 12'h33C, 12'h343, 12'h344, 12'h345};
      unit_tab = '{4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                   4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};
      for (int v = 0; v <= 12; v++) begin
         accept(8'(v), 1'b1);
         wait_valid(n);
         n_vec++;
         if (out_code !== exp_tab[v]) begin
            n_err++;
            $display("FAIL sweep_%0d: got %h, want %h", v, out_code, exp_tab[v]);
         end
         if (v <= 9) begin
            n_vec++;
            if (out_code[3:0] !== unit_tab[v]) begin
               n_err++;
               $display("FAIL units_%0d: got %b, want %b", v, out_code[3:0], unit_tab[v]);
            end
         end
         drain();
      end
   endtask

   task automatic test_backpressure();
      int n;
      accept(8'd137, 1'b0);
      wait_valid(n);
      for (int c = 0; c < 5; c++) begin
         n_vec++;
         if (out_code !== 12'h137 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_%0d: got code=%h rdy=%b vld=%b, want 137 0 1",
                     c, out_code, in_ready, out_valid);
         end
         in_valid = (c == 2);
         in_bin   = 8'd5;
         @(negedge clk);
      end
      in_valid = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL ignored_pulse: got vld=%b busy=%b rdy=%b, want 0 0 1",
                  out_valid, busy, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1;
      in_bin   = 8'd42;
      in_mode  = 1'b1;
      @(negedge clk);
      in_bin   = 8'd99;
      wait_valid(n);
      n_vec++;
      if (out_code !== 12'h375 || n !== 8) begin
         n_err++;
         $display("FAIL b2b_first: got %h after %0d, want 375 after 8", out_code, n);
      end
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_idle: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_accept: got busy=%b, want 1", busy);
      end
      wait_valid(n);
      n_vec++;
      if (out_code !== 12'h3CC || n !== 8) begin
         n_err++;
         $display("FAIL b2b_second: got %h after %0d, want 3CC after 8", out_code, n);
      end
      out_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_conv();
      int n;
      accept(8'd200, 1'b1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({in_ready, out_valid, busy, out_code} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
         n_err++;
         $display("FAIL mid_reset: got rdy=%b vld=%b busy=%b code=%h, want 1 0 0 000",
                  in_ready, out_valid, busy, out_code);
      end
      #3;
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL discarded: got vld=%b, want 0", out_valid);
      end
      accept(8'd7, 1'b0);
      wait_valid(n);
      n_vec++;
      if (out_code !== 12'h007) begin
         n_err++;
         $display("FAIL after_reset: got %h, want 007", out_code);
      end
      drain();
   endtask

   initial begin
      in_valid  = 1'b0;
      in_bin    = 8'd0;
      in_mode   = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_zero_latency();
      test_max();
      test_sweep();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_conv();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
